// File: rtl/round_key_store_pkg.sv
// -----------------------------------------------------------------------------
// round_key_store_pkg
// Shared constants and types for the round-key store: number of stored keys,
// key width, the round index type and the controller state encoding.
// -----------------------------------------------------------------------------
package round_key_store_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int KEY_W      = 96;

  typedef logic [$clog2(NUM_ROUNDS)-1:0] round_idx_t;

  localparam round_idx_t ROUND_LAST   = round_idx_t'(NUM_ROUNDS - 1);
  localparam round_idx_t ROUND_PENULT = round_idx_t'(NUM_ROUNDS - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_SERVE = 2'd3
  } state_t;

endpackage

// File: rtl/round_key_store_key_bank.sv
// -----------------------------------------------------------------------------
// key_bank
// NUM_ROUNDS x KEY_W register file: one synchronous write port, one
// combinational read port.
// Ports:
//   clk      clock, rising edge
//   we       write enable
//   wr_addr  write index
//   wr_data  write data
//   rd_addr  read index
//   rd_data  read data (combinational)
// -----------------------------------------------------------------------------
module key_bank
  import round_key_store_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  round_idx_t       wr_addr,
  input  logic [KEY_W-1:0] wr_data,
  input  round_idx_t       rd_addr,
  output logic [KEY_W-1:0] rd_data
);

  logic [KEY_W-1:0] mem [NUM_ROUNDS];

  // NOTE: storage has no reset on purpose; every entry is written before it
  // can be read (keys_ready gates serving), so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/round_key_store.sv
// -----------------------------------------------------------------------------
// round_key_store
// Captures the 16 round keys streamed by the key schedule and serves them one
// per handshake to the Feistel round datapath. Keys are reused across any
// number of serving passes until the next load.
// Optional feature: define DECRYPT_REVERSE_EN to let mode=1 serve the keys in
// reverse order (decryption). Without it, mode is ignored and passes are
// always forward.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   load_start      pulse: clear the store and begin capturing keys
//   key_valid/key_in  incoming round key strobe and data (round 1..16 order)
//   start           pulse: begin one serving pass (accepted only when ready)
//   mode            0 forward, 1 reverse; sampled with an accepted start
//   key_req         consumer takes key_out this cycle
//   key_out         registered round key
//   key_out_valid   key_out holds a key of the current pass
//   round           index of the key on key_out
//   last_round      key_out is the final key of the pass
//   keys_ready      all keys are stored
//   err_overflow    sticky: key strobe arrived after the store was full
// -----------------------------------------------------------------------------
module round_key_store
  import round_key_store_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_in,
  input  logic             start,
  input  logic             mode,
  input  logic             key_req,
  output logic [KEY_W-1:0] key_out,
  output logic             key_out_valid,
  output round_idx_t       round,
  output logic             last_round,
  output logic             keys_ready,
  output logic             err_overflow
);

  state_t           state_q;
  round_idx_t       wr_ptr_q;
  round_idx_t       pass_cnt_q;   // position within the pass, 0..15
  round_idx_t       first_idx;
  round_idx_t       next_idx;
  round_idx_t       rd_addr;
  logic [KEY_W-1:0] rd_data;
  logic             bank_we;

`ifdef DECRYPT_REVERSE_EN
  logic rev_q;
  assign first_idx = mode ? ROUND_LAST : '0;
  assign next_idx  = rev_q ? round - 4'd1 : round + 4'd1;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign first_idx   = '0;
  assign next_idx    = round + 4'd1;
`endif

  // load_start wins over a simultaneous key strobe: that key is dropped.
  assign bank_we = (state_q == ST_LOAD) && key_valid && !load_start;

  // Look ahead one key so the output register can load it on the handshake.
  // NOTE: default assignment first keeps this block purely combinational;
  // a path that leaves rd_addr unassigned would infer a latch.
  always_comb begin
    rd_addr = next_idx;
    if (state_q == ST_READY) rd_addr = first_idx;
  end

  key_bank u_key_bank (
    .clk     (clk),
    .we      (bank_we),
    .wr_addr (wr_ptr_q),
    .wr_data (key_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      pass_cnt_q    <= '0;
      key_out       <= '0;
      key_out_valid <= 1'b0;
      round         <= '0;
      last_round    <= 1'b0;
      keys_ready    <= 1'b0;
      err_overflow  <= 1'b0;
`ifdef DECRYPT_REVERSE_EN
      rev_q         <= 1'b0;
`endif
    end else if (load_start) begin
      // Restart capture from any state; an in-progress pass is abandoned.
      state_q       <= ST_LOAD;
      wr_ptr_q      <= '0;
      key_out_valid <= 1'b0;
      last_round    <= 1'b0;
      keys_ready    <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_LOAD: begin
          if (key_valid) begin
            wr_ptr_q <= wr_ptr_q + 4'd1;
            if (wr_ptr_q == ROUND_LAST) begin
              state_q    <= ST_READY;
              keys_ready <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (key_valid) err_overflow <= 1'b1;
          if (start) begin
            state_q       <= ST_SERVE;
            round         <= first_idx;
            key_out       <= rd_data;
            pass_cnt_q    <= '0;
            key_out_valid <= 1'b1;
            last_round    <= 1'b0;
`ifdef DECRYPT_REVERSE_EN
            rev_q         <= mode;
`endif
          end
        end
        ST_SERVE: begin
          if (key_valid) err_overflow <= 1'b1;
          if (key_req && key_out_valid) begin
            if (pass_cnt_q == ROUND_LAST) begin
              // key_out keeps its last value; only valid drops.
              state_q       <= ST_READY;
              key_out_valid <= 1'b0;
              last_round    <= 1'b0;
            end else begin
              round      <= next_idx;
              key_out    <= rd_data;
              pass_cnt_q <= pass_cnt_q + 4'd1;
              last_round <= (pass_cnt_q == ROUND_PENULT);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_key_store.sv
module tb_round_key_store;
  import round_key_store_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_start;
  logic             key_valid;
  logic [KEY_W-1:0] key_in;
  logic             start;
  logic             mode;
  logic             key_req;
  logic [KEY_W-1:0] key_out;
  logic             key_out_valid;
  logic [3:0]       round;
  logic             last_round;
  logic             keys_ready;
  logic             err_overflow;

  int tests_run = 0;
  int fails     = 0;

  round_key_store dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_start    (load_start),
    .key_valid     (key_valid),
    .key_in        (key_in),
    .start         (start),
    .mode          (mode),
    .key_req       (key_req),
    .key_out       (key_out),
    .key_out_valid (key_out_valid),
    .round         (round),
    .last_round    (last_round),
    .keys_ready    (keys_ready),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  // Key i is byte (i+1) replicated across all 12 bytes.
  function automatic logic [KEY_W-1:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i + 1);
    return {12{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a load: load_start (optionally with a colliding strobe), then 16
  // back-to-back keys. keys_ready must rise only after the 16th.
  task automatic load_keys(input bit collide, input string tag);
    load_start = 1'b1;
    key_valid  = collide;
    key_in     = '1;
    tick();
    load_start = 1'b0;
    key_valid  = 1'b0;
    if (collide) begin
      tests_run++;
      if (err_overflow !== 1'b0 || keys_ready !== 1'b0 || key_out_valid !== 1'b0) begin
        fails++;
        $display("FAIL %s_clear: err=%b ready=%b valid=%b, want 0 0 0", tag, err_overflow, keys_ready, key_out_valid);
      end
    end
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      key_valid = 1'b1;
      key_in    = pat(i);
      tick();
      if (i == NUM_ROUNDS - 2) begin
        tests_run++;
        if (keys_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s_ready_early: keys_ready=%b after 15 keys, want 0", tag, keys_ready);
        end
      end
    end
    key_valid = 1'b0;
    tests_run++;
    if (keys_ready !== 1'b1 || err_overflow !== 1'b0) begin
      fails++;
      $display("FAIL %s_ready: keys_ready=%b err=%b, want 1 0", tag, keys_ready, err_overflow);
    end
  endtask

  // One serving pass; stall toggles key_req 1-0-1-0. Checks every presented
  // key against the expected order, then the drop of valid after the final one.
  task automatic run_pass(input bit m, input bit stall, input string tag);
    int k, cyc, e;
    bit rev;
`ifdef DECRYPT_REVERSE_EN
    rev = m;
`else
    rev = 1'b0;
`endif
    start   = 1'b1;
    mode    = m;
    key_req = 1'b0;
    tick();
    start = 1'b0;
    mode  = ~m;  // mode must have been latched at start
    k   = 0;
    cyc = 0;
    e   = 0;
    while (k < NUM_ROUNDS && cyc < 64) begin
      e = rev ? (NUM_ROUNDS - 1 - k) : k;
      tests_run++;
      if (key_out_valid !== 1'b1 || key_out !== pat(e) || round !== 4'(e) ||
          last_round !== (k == NUM_ROUNDS - 1)) begin
        fails++;
        $display("FAIL %s_key%0d: valid=%b key=%h round=%0d last=%b, want 1 %h %0d %b",
                 tag, k, key_out_valid, key_out, round, last_round, pat(e), e, (k == NUM_ROUNDS - 1));
      end
      key_req = stall ? (cyc % 2 == 0) : 1'b1;
      tick();
      if (key_req) k++;
      cyc++;
    end
    key_req = 1'b0;
    tests_run++;
    if (k < NUM_ROUNDS) begin
      fails++;
      $display("FAIL %s_timeout: only %0d keys in %0d cycles, want 16", tag, k, cyc);
    end
    tests_run++;
    if (key_out_valid !== 1'b0 || last_round !== 1'b0 || key_out !== pat(e)) begin
      fails++;
      $display("FAIL %s_end: valid=%b last=%b key=%h, want 0 0 %h", tag, key_out_valid, last_round, key_out, pat(e));
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (key_out !== '0 || key_out_valid !== 1'b0 || round !== 4'd0 ||
        last_round !== 1'b0 || keys_ready !== 1'b0 || err_overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset: key=%h valid=%b round=%0d last=%b ready=%b err=%b, want all 0",
               key_out, key_out_valid, round, last_round, keys_ready, err_overflow);
    end
    // Start and key strobes are ignored in IDLE.
    start     = 1'b1;
    key_valid = 1'b1;
    key_in    = '1;
    tick();
    start     = 1'b0;
    key_valid = 1'b0;
    tick();
    tests_run++;
    if (key_out_valid !== 1'b0 || keys_ready !== 1'b0 || err_overflow !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignore: valid=%b ready=%b err=%b, want 0 0 0", key_out_valid, keys_ready, err_overflow);
    end
  endtask

  task automatic test_load();
    load_keys(1'b0, "load");
  endtask

  task automatic test_forward();
    run_pass(1'b0, 1'b0, "fwd");
  endtask

  task automatic test_back_to_back();
    run_pass(1'b0, 1'b0, "b2b_a");
    run_pass(1'b0, 1'b0, "b2b_b");
  endtask

  task automatic test_reverse();
    run_pass(1'b1, 1'b0, "rev");
  endtask

  task automatic test_stall();
    run_pass(1'b0, 1'b1, "stall");
  endtask

  task automatic test_overflow();
    key_valid = 1'b1;
    key_in    = '1;
    tick();
    key_valid = 1'b0;
    tests_run++;
    if (err_overflow !== 1'b1 || keys_ready !== 1'b1) begin
      fails++;
      $display("FAIL overflow_flag: err=%b ready=%b, want 1 1", err_overflow, keys_ready);
    end
    // Stored keys must be intact; flag stays sticky through the pass.
    run_pass(1'b0, 1'b0, "ovf_pass");
    tests_run++;
    if (err_overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky: err=%b, want 1", err_overflow);
    end
  endtask

  task automatic test_load_collision();
    load_keys(1'b1, "collide");
    run_pass(1'b0, 1'b0, "collide_pass");
  endtask

  task automatic test_reset_mid_pass();
    start   = 1'b1;
    mode    = 1'b0;
    tick();
    start   = 1'b0;
    key_req = 1'b1;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    key_req = 1'b0;
    tests_run++;
    if (key_out !== '0 || key_out_valid !== 1'b0 || round !== 4'd0 ||
        last_round !== 1'b0 || keys_ready !== 1'b0 || err_overflow !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: key=%h valid=%b round=%0d last=%b ready=%b err=%b, want all 0",
               key_out, key_out_valid, round, last_round, keys_ready, err_overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests_run++;
    if (key_out_valid !== 1'b0 || keys_ready !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_start: valid=%b ready=%b, want 0 0", key_out_valid, keys_ready);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    key_valid  = 1'b0;
    key_in     = '0;
    start      = 1'b0;
    mode       = 1'b0;
    key_req    = 1'b0;
    #12;
    test_reset_check_and_release();
    test_reset();
    test_load();
    test_forward();
    test_back_to_back();
    test_reverse();
    test_stall();
    test_overflow();
    test_load_collision();
    test_reset_mid_pass();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  task automatic test_reset_check_and_release();
    tests_run++;
    if (key_out_valid !== 1'b0 || keys_ready !== 1'b0 || round !== 4'd0) begin
      fails++;
      $display("FAIL in_reset: valid=%b ready=%b round=%0d, want 0 0 0", key_out_valid, keys_ready, round);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

endmodule

// File: doc/round_key_store.md
# round_key_store

Buffers the 16 96-bit round keys produced serially by the key-schedule stage and serves them, one per handshake, to the downstream Feistel round datapath. Decouples key generation from block processing: the schedule runs once per key load, then any number of block passes reuse the stored keys. Forward order is used for encryption; reverse order for decryption when compiled in.

## Interface
- NUM_ROUNDS, 16, number of stored round keys; counters are 4 bits.
- KEY_W, 96, round-key width.
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low.
- Load_start  in  1  pulse; clear store, begin capturing keys.
- Key_valid  in  1  upstream strobe; Key_in holds a valid round key this cycle.
- Key_in  in  KEY_W  round key from key schedule, round order 1..16.
- Start  in  1  pulse; begin one serving pass.
- Mode  in  1  0 = encrypt (forward), 1 = decrypt (reverse); sampled on accepted Start.
- Key_req  in  1  consumer takes Key_out this cycle.
- Key_out  out  KEY_W  registered round key.
- Key_out_valid  out  1  Key_out is valid.
- Round  out  4  index of the key on Key_out (0..15 = round 1..16).
- Last_round  out  1  Key_out is the final key of the pass.
- Keys_ready  out  1  all 16 keys are stored.
- Err_overflow  out  1  sticky; key strobe arrived after the store was full.

## Operation
- States: IDLE, LOAD, READY, SERVE.
- IDLE: Key_valid and Start ignored. Load_start -> LOAD.
- LOAD: each Key_valid writes Key_in at wr_ptr, wr_ptr++. The 16th write -> READY; Keys_ready=1 from the next cycle.
- READY: Start -> SERVE; rd_ptr = 0 (forward) or 15 (reverse); Mode latched.
- SERVE: transfer = Key_req && Key_out_valid. Each transfer steps rd_ptr +1 (forward) or -1 (reverse). The transfer of the 16th key returns to READY. Start in SERVE is ignored.
- Key_valid in READY or SERVE: key discarded; Err_overflow=1 until the next Load_start.
- Load_start in any state: goes to LOAD, wr_ptr=0, Keys_ready=0, Key_out_valid=0, Err_overflow=0. An in-progress pass is aborted.
- Load_start and Key_valid in the same cycle: Load_start wins; the key is not written.
- Key_req while Key_out_valid=0: ignored.
- Last_round=1 exactly while Key_out_valid and the 16th key of the pass is presented.

## Timing
- Reset: state=IDLE. All outputs are 0: Key_out, Key_out_valid, Round, Last_round, Keys_ready, Err_overflow. Key storage is not reset.
- Load: one key per cycle, back-to-back strobes allowed. A 16th strobe at cycle N gives Keys_ready=1 at N+1.
- Start accepted at N: Key_out/Round/Key_out_valid are valid at N+1.
- Key_req at N with valid: the next key is on Key_out at N+1. Sustained throughput is 1 key/cycle; a full pass takes 16 cycles with Key_req held high.
- Final transfer at N: Key_out_valid=0 at N+1; Key_out holds its last value.
- A new Start may be accepted at N+1 after the final transfer.

## Configuration
- DECRYPT_REVERSE_EN defined: Mode selects forward or reverse readout.
- DECRYPT_REVERSE_EN not defined: Mode is ignored and always treated as forward; the down-count logic is removed. Port list is unchanged.

## Structure
- Package round_key_store_pkg holds NUM_ROUNDS, KEY_W, the state enum, and the round index type.
- Sub-module key_bank: 16 x KEY_W register file with one synchronous write port and one combinational read port. The registered output stage sits in the top module.

## Test plan
- Key pattern: key i (i=0..15) = byte (i+1) replicated 12 times, e.g. key0=96'h0101…01, key15=96'h1010…10.
- Reset low mid-pass -> all outputs 0 immediately, state IDLE; after release, Start is ignored and Keys_ready stays 0.
- Load_start, then 16 back-to-back Key_valid -> Keys_ready=1 one cycle after the 16th strobe; Err_overflow=0.
- Start with Mode=0, Key_req held high -> Key_out sequence 0x01…01 through 0x10…10 over 16 cycles; Round 0..15; Last_round only on key15; Key_out_valid drops the cycle after.
- Start with Mode=1 (DECRYPT_REVERSE_EN defined) -> key15 first, key0 last with Last_round=1. Without the macro -> forward order.
- Key_req toggled 1-0-1 during a pass -> key advances only on cycles with Key_req=1; no key skipped or duplicated.
- 17th Key_valid in READY -> Err_overflow=1, stored keys unchanged. Load_start asserted together with Key_valid -> Err_overflow=0, wr_ptr=0, that key not written.
